rv32i_mem_arbiter: RTL and testbench
====================================

RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, is the number of BUSY cycles without m_ack before the transaction aborts; the legal range is 2..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  instruction-fetch request, held until i_ack or i_err.
REQ-005 i_addr  input  32  fetch address, stable while i_req is high.
REQ-006 i_rdata  output  32  fetched word, valid with i_ack.
REQ-007 i_ack / i_err  output  1 each  one-cycle completion pulse / one-cycle timeout pulse for the fetch port.
REQ-008 d_req  input  1  data (load/store) request, held until d_ack or d_err.
REQ-009 d_we  input  1  1 means store, 0 means load.
REQ-010 d_addr, d_wdata  input  32 each  data address and store data.
REQ-011 d_wstrb  input  4  byte enables for stores.
REQ-012 d_rdata  output  32  load data, valid with d_ack.
REQ-013 d_ack / d_err  output  1 each  completion pulse / timeout pulse for the data port.
REQ-014 m_req, m_we  output  1 each  shared memory request and write enable.
REQ-015 m_addr, m_wdata  output  32 each  address and write data to memory.
REQ-016 m_wstrb  output  4  byte enables to memory.
REQ-017 m_rdata  input  32  memory read data, valid with m_ack.
REQ-018 m_ack  input  1  memory completion, asserted for one cycle.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BUSY and RESP; owner (I or D) and last_grant registers SHALL accompany it.
REQ-020 In IDLE with exactly one request high, the arbiter SHALL grant that port; with both high, it SHALL grant the port that is not last_grant.
REQ-021 On a grant, the arbiter SHALL enter BUSY at the next edge and register m_req=1 together with the owner's addr, we, wdata and wstrb.
REQ-022 For a fetch grant, m_we SHALL be 0, m_wstrb SHALL be 4'b0000 and m_wdata SHALL be 0.
REQ-023 In BUSY, m_req and all m_* fields SHALL stay constant until m_ack or timeout; requester inputs are not re-sampled.
REQ-024 On m_ack in BUSY, at the next edge: state becomes RESP, m_req becomes 0, the owner's ack becomes 1, and the owner's rdata takes m_rdata for loads and 0 for stores.
REQ-025 The BUSY cycle counter SHALL reset to 0 on entry to BUSY and increment on every BUSY cycle without m_ack.
REQ-026 If the counter reaches TIMEOUT_CYCLES-1 with m_ack low, at the next edge the state becomes RESP, m_req becomes 0, the owner's err becomes 1 and rdata becomes 0.
REQ-027 If m_ack and the timeout coincide, m_ack SHALL win: ack is asserted and err is not.
REQ-028 RESP SHALL last exactly one cycle, then return to IDLE; ack and err SHALL be high only in RESP, and only for the owner.
REQ-029 last_grant SHALL update to the owner on leaving RESP.
REQ-030 The requester SHALL drop req during RESP; a request still high in IDLE is treated as a new request.
REQ-031 m_ack SHALL be ignored in IDLE and RESP.
REQ-032 Minimum transaction is 3 cycles: grant edge, then BUSY with m_ack in its first cycle, then RESP.
REQ-033 rdata outputs SHALL hold their last value outside RESP.

Reset
REQ-034 rst SHALL force state=IDLE, counter=0, last_grant=D (so I wins the first conflict) and owner=I at the next edge.
REQ-035 rst SHALL force all outputs (m_*, i_*, d_*) to 0 at the next edge.
REQ-036 rst during BUSY SHALL abort the transaction silently, with no ack and no err; a late m_ack after reset is ignored per REQ-031.

Structure
REQ-037 State encodings (IDLE=0, BUSY=1, RESP=2), owner encodings (I=0, D=1) and the TIMEOUT_CYCLES default SHALL reside in the shared package rv32i_pkg.
REQ-038 Two-way round-robin selection SHALL be a sub-module, rv32i_rr_arb2: inputs req[1:0] and last; output gnt[1:0], one-hot or zero; purely combinational.
REQ-039 The total implementation SHALL be 120-400 lines of RTL.

Verification
REQ-040 Fetch only: i_req=1, i_addr=0x0000_0100; memory acks 2 cycles into BUSY with m_rdata=0x0000_0013 -> m_addr=0x100, m_we=0, i_ack pulses once, i_rdata=0x13, d_ack=0.
REQ-041 Simultaneous requests after reset (fetch 0x200, store 0x1000 with wdata 0xDEADBEEF, wstrb 0xF) -> fetch served first, then the store with m_we=1 and m_wstrb=0xF; on a repeated conflict the data port wins.
REQ-042 Timeout: TIMEOUT_CYCLES=4, d_req load, m_ack never asserted -> d_err pulses exactly 4 cycles after BUSY entry, d_ack=0, m_req=0 during RESP.
REQ-043 m_ack in the same cycle the counter hits 3 (TIMEOUT_CYCLES=4) -> ack asserted, err not asserted.
REQ-044 rst in the 2nd BUSY cycle of a store, followed by m_ack one cycle later -> all outputs 0, no ack or err, FSM in IDLE, next i_req served normally.
REQ-045 Back-to-back fetch with i_req held through RESP -> a second grant occurs from IDLE with no lost or duplicated ack.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared encodings and defaults for the rv32i memory arbiter
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rv32i_rr_arb2.sv
// rtl/rv32i_rr_arb2.sv - two-way round-robin selector, bit 0 = fetch, bit 1 = data
module rv32i_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a conflict the port that did not win last time gets the grant.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rtl/rv32i_mem_arbiter.sv - shares one memory port between fetch and load/store requesters
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;
    logic        i_ack_q, i_ack_d;
    logic        i_err_q, i_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_ack_q, d_ack_d;
    logic        d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [1:0]  gnt;

    rv32i_rr_arb2 u_rr (
        .req  ({d_req, i_req}),
        .last (last_q == OWNER_D),
        .gnt  (gnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        d_ack_d   = 1'b0;
        d_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    state_d = BUSY;
                    cnt_d   = 8'd0;
                    m_req_d = 1'b1;
                    if (gnt[1]) begin
                        owner_d   = OWNER_D;
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_wstrb_d = d_wstrb;
                    end else begin
                        owner_d   = OWNER_I;
                        m_we_d    = 1'b0;
                        m_addr_d  = i_addr;
                        m_wdata_d = 32'd0;
                        m_wstrb_d = 4'b0000;
                    end
                end
            end
            BUSY: begin
                // A completing m_ack takes priority over an expiring counter.
                if (m_ack) begin
                    state_d = RESP;
                    m_req_d = 1'b0;
                    if (owner_q == OWNER_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_we_q ? 32'd0 : m_rdata;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    m_req_d = 1'b0;
                    if (owner_q == OWNER_D) begin
                        d_err_d   = 1'b1;
                        d_rdata_d = 32'd0;
                    end else begin
                        i_err_d   = 1'b1;
                        i_rdata_d = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_I;
            last_q    <= OWNER_D;
            cnt_q     <= 8'd0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            m_wstrb_q <= 4'b0000;
            i_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            i_rdata_q <= 32'd0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
            i_ack_q   <= i_ack_d;
            i_err_q   <= i_err_d;
            i_rdata_q <= i_rdata_d;
            d_ack_q   <= d_ack_d;
            d_err_q   <= d_err_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign i_ack   = i_ack_q;
    assign i_err   = i_err_q;
    assign i_rdata = i_rdata_q;
    assign d_ack   = d_ack_q;
    assign d_err   = d_err_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb/tb_rv32i_mem_arbiter.sv - scoreboard bench for rv32i_mem_arbiter
module tb_rv32i_mem_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_wstrb;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ack, i_err, d_ack, d_err, m_req, m_we;
    logic [3:0]  m_wstrb;

    rv32i_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push_exp(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t e;
        e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; m_rdata = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Memory responder + scoreboard consumer for one transaction; ack_at < 0 means never ack.
    task automatic serve_one(input int ack_at, input logic [31:0] rd, input bit keep);
        exp_t        e;
        int          n, k;
        bit          done, exp_err;
        int          exp_len;
        logic [31:0] exp_rd, got_rd;
        logic        got_ack, got_err, oth;
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL sb_empty: queue size=0 required >0"); return;
        end
        e = sb.pop_front();
        n = 0;
        while (m_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (m_req !== 1'b1) begin
            errors++; $display("FAIL grant_wait: m_req=%b required 1", m_req); return;
        end
        checks++;
        if (m_addr !== e.addr || m_we !== e.we || m_wdata !== e.wdata || m_wstrb !== e.wstrb) begin
            errors++;
            $display("FAIL m_fields: addr=%h we=%b wdata=%h wstrb=%h required %h %b %h %h",
                     m_addr, m_we, m_wdata, m_wstrb, e.addr, e.we, e.wdata, e.wstrb);
        end
        m_rdata = rd;
        k = 0; done = 0;
        while (!done && k < 40) begin
            m_ack = (k == ack_at);
            @(negedge clk);
            m_ack = 1'b0;
            k++;
            done = (i_ack === 1'b1) || (i_err === 1'b1) || (d_ack === 1'b1) || (d_err === 1'b1);
            if (!done && (m_addr !== e.addr || m_req !== 1'b1)) begin
                checks++; errors++;
                $display("FAIL busy_hold: m_req=%b m_addr=%h required 1 %h", m_req, m_addr, e.addr);
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL resp_wait: no ack/err after %0d cycles required completion", k);
            return;
        end
        exp_err = !(ack_at >= 0 && ack_at < T);
        exp_len = exp_err ? T : ack_at + 1;
        exp_rd  = (exp_err || e.we) ? 32'd0 : rd;
        got_ack = e.is_d ? d_ack : i_ack;
        got_err = e.is_d ? d_err : i_err;
        oth     = e.is_d ? (i_ack | i_err) : (d_ack | d_err);
        got_rd  = e.is_d ? d_rdata : i_rdata;
        checks++;
        if (k !== exp_len) begin
            errors++; $display("FAIL busy_len: %0d cycles required %0d", k, exp_len);
        end
        checks++;
        if (got_ack !== !exp_err || got_err !== exp_err || oth !== 1'b0) begin
            errors++;
            $display("FAIL resp_kind: ack=%b err=%b other=%b required %b %b 0",
                     got_ack, got_err, oth, !exp_err, exp_err);
        end
        checks++;
        if (got_rd !== exp_rd) begin
            errors++; $display("FAIL rdata: %h required %h", got_rd, exp_rd);
        end
        checks++;
        if (m_req !== 1'b0) begin
            errors++; $display("FAIL m_req_resp: %b required 0", m_req);
        end
        if (!keep) begin
            if (e.is_d) d_req = 1'b0; else i_req = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({i_ack, i_err, d_ack, d_err} !== 4'b0000) begin
            errors++; $display("FAIL resp_pulse: ack/err=%b required 0000", {i_ack, i_err, d_ack, d_err});
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({m_req, m_we, m_addr, m_wdata, m_wstrb} !== '0) begin
            errors++; $display("FAIL reset_m: req=%b addr=%h required 0", m_req, m_addr);
        end
        checks++;
        if ({i_rdata, i_ack, i_err} !== '0) begin
            errors++; $display("FAIL reset_i: rdata=%h ack=%b err=%b required 0", i_rdata, i_ack, i_err);
        end
        checks++;
        if ({d_rdata, d_ack, d_err} !== '0) begin
            errors++; $display("FAIL reset_d: rdata=%h ack=%b err=%b required 0", d_rdata, d_ack, d_err);
        end
    endtask

    task automatic test_fetch_only();
        push_exp(0, 0, 32'h0000_0100, 32'd0, 4'h0);
        i_addr = 32'h0000_0100; i_req = 1'b1;
        serve_one(2, 32'h0000_0013, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (i_rdata !== 32'h0000_0013 || d_rdata !== 32'd0) begin
            errors++; $display("FAIL fetch_hold: i_rdata=%h d_rdata=%h required 00000013 0", i_rdata, d_rdata);
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        i_addr = 32'h0000_0200; i_req = 1'b1;
        d_we = 1'b1; d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; d_req = 1'b1;
        push_exp(0, 0, 32'h0000_0200, 32'd0, 4'h0);
        push_exp(1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        push_exp(0, 0, 32'h0000_0200, 32'd0, 4'h0);
        serve_one(0, 32'h1111_0000, 1);
        serve_one(1, 32'h5555_5555, 0);
        serve_one(0, 32'h2222_0000, 0);
    endtask

    task automatic test_timeout();
        d_we = 1'b0; d_addr = 32'h0000_0040; d_wdata = 32'h0000_00AA; d_wstrb = 4'h0; d_req = 1'b1;
        push_exp(1, 0, 32'h0000_0040, 32'h0000_00AA, 4'h0);
        serve_one(1, 32'hCAFE_0001, 0);
        d_addr = 32'h0000_0044; d_req = 1'b1;
        push_exp(1, 0, 32'h0000_0044, 32'h0000_00AA, 4'h0);
        serve_one(-1, 32'hABCD_0000, 0);
    endtask

    task automatic test_coincide();
        d_we = 1'b0; d_addr = 32'h0000_0080; d_wdata = 32'd0; d_req = 1'b1;
        push_exp(1, 0, 32'h0000_0080, 32'd0, 4'h0);
        serve_one(T - 1, 32'h0000_0077, 0);
    endtask

    task automatic test_reset_busy();
        int n;
        d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'h1234_5678; d_wstrb = 4'h3; d_req = 1'b1;
        n = 0;
        while (m_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (m_req !== 1'b1) begin
            errors++; $display("FAIL rb_grant: m_req=%b required 1", m_req);
        end
        @(negedge clk);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
        checks++;
        if ({m_req, m_we, m_addr, m_wdata, m_wstrb, i_rdata, i_ack, i_err, d_rdata, d_ack, d_err} !== '0) begin
            errors++;
            $display("FAIL rb_outputs: m_req=%b m_addr=%h d_rdata=%h d_ack=%b d_err=%b required all 0",
                     m_req, m_addr, d_rdata, d_ack, d_err);
        end
        @(negedge clk);
        m_ack = 1'b0;
        checks++;
        if ({m_req, i_ack, i_err, d_ack, d_err, d_rdata} !== '0) begin
            errors++;
            $display("FAIL rb_late_ack: m_req=%b ack/err=%b d_rdata=%h required 0",
                     m_req, {i_ack, i_err, d_ack, d_err}, d_rdata);
        end
        i_addr = 32'h0000_0500; i_req = 1'b1;
        push_exp(0, 0, 32'h0000_0500, 32'd0, 4'h0);
        serve_one(1, 32'h0000_0099, 0);
    endtask

    task automatic test_back_to_back();
        i_addr = 32'h0000_0600; i_req = 1'b1;
        push_exp(0, 0, 32'h0000_0600, 32'd0, 4'h0);
        push_exp(0, 0, 32'h0000_0600, 32'd0, 4'h0);
        serve_one(0, 32'h0000_000A, 1);
        serve_one(2, 32'h0000_000B, 0);
        repeat (3) @(negedge clk);
        checks++;
        if ({m_req, i_ack, i_err} !== 3'b000 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_idle: m_req=%b ack=%b err=%b pending=%0d required 0 0 0 0",
                     m_req, i_ack, i_err, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_only();
        test_conflict();
        test_timeout();
        test_coincide();
        test_reset_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
